// File: rtl/lr_consistency_check_param.sv
// lr_consistency_check_param
//
// Left-right disparity consistency check for the stereo pipeline. Each left
// disparity dL at column x is compared against the right disparity found at
// column x-dL. The pixel keeps dL when the two agree within a runtime
// tolerance, and is replaced by INVALID_VALUE otherwise. A bypass mode passes
// dL through unchanged. The block also counts invalid pixels per frame and
// flags left/right SOF misalignment.
//
// Ports
//   clk                   pipeline clock
//   rst_n                 asynchronous reset, active low
//   en, pixelEN           a beat is a cycle with en & pixelEN
//   Disparity_Left        {SOF, dL}
//   Disparity_Right       {SOF, dR}, column-aligned with the left stream
//   check_en              1 = check, 0 = bypass
//   tolerance             maximum allowed |dL - dR|
//   dispOutput_left       {SOF, checked disparity}, two beats after input
//   dispOutput_left_valid one-cycle pulse when dispOutput_left is updated
//   invalid_count         invalid pixels counted in the last completed frame
//   sync_err              sticky left/right SOF mismatch flag
module lr_consistency_check_param #(
  parameter int MAXDISPARITY  = 64,
  parameter int DISP_WIDTH    = 8,
  parameter int INPUTDATAWID  = 9,
  parameter int OUTPUTDATAWID = 9,
  parameter int IMAGE_WIDTH   = 640,
  parameter int INVALID_VALUE = 0,
  parameter int CNT_WIDTH     = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     pixelEN,
  input  logic [INPUTDATAWID-1:0]  Disparity_Left,
  input  logic [INPUTDATAWID-1:0]  Disparity_Right,
  input  logic                     check_en,
  input  logic [3:0]               tolerance,
  output logic [OUTPUTDATAWID-1:0] dispOutput_left,
  output logic                     dispOutput_left_valid,
  output logic [CNT_WIDTH-1:0]     invalid_count,
  output logic                     sync_err
);

  localparam int XW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [XW-1:0]         X_LAST   = XW'(IMAGE_WIDTH - 1);
  localparam logic [DISP_WIDTH-1:0] INV_CODE = DISP_WIDTH'(INVALID_VALUE);

  logic                  beat;
  logic                  sof_l, sof_r;
  logic [DISP_WIDTH-1:0] dl, dr;

  assign beat  = en & pixelEN;
  assign sof_l = Disparity_Left[INPUTDATAWID-1];
  assign sof_r = Disparity_Right[INPUTDATAWID-1];
  assign dl    = Disparity_Left[DISP_WIDTH-1:0];
  assign dr    = Disparity_Right[DISP_WIDTH-1:0];

  // Column counter
  logic [XW-1:0] x_q, x_d;

  always_comb begin
    if (sof_l) begin
      x_d = '0;
    end else if (x_q == X_LAST) begin
      x_d = '0;
    end else begin
      x_d = x_q + 1'b1;
    end
  end

  // Right-disparity history. The lookup window includes the current pixel at
  // index 0, so only MAXDISPARITY-1 past values need storage:
  // rwin_q[k] holds dR(x-1-k) relative to the current column.
  logic [DISP_WIDTH-1:0] rwin_q [MAXDISPARITY-1];
  logic [DISP_WIDTH-1:0] win    [MAXDISPARITY];
  logic [DISP_WIDTH-1:0] rsel_d;
  logic                  oob_d;

  always_comb begin
    win[0] = dr;
    for (int k = 1; k < MAXDISPARITY; k++) begin
      win[k] = rwin_q[k-1];
    end
  end

  // dL outside the window never matches an index and selects 0
  always_comb begin
    rsel_d = '0;
    for (int k = 0; k < MAXDISPARITY; k++) begin
      if (int'(dl) == k) rsel_d = win[k];
    end
  end

  assign oob_d = (int'(dl) >= MAXDISPARITY) || (int'(dl) > int'(x_d));

  // Stage 1 registers
  logic [DISP_WIDTH-1:0] s1_dl_q, s1_rsel_q;
  logic                  s1_sof_q, s1_oob_q, s1_chk_q;
  logic [3:0]            s1_tol_q;

  // Stage 2 decision
  logic [DISP_WIDTH:0]   s2_a, s2_b, diff_d;
  logic                  reject_d;
  logic [DISP_WIDTH-1:0] out_d;

  assign s2_a     = {1'b0, s1_dl_q};
  assign s2_b     = {1'b0, s1_rsel_q};
  assign diff_d   = (s2_a >= s2_b) ? (s2_a - s2_b) : (s2_b - s2_a);
  assign reject_d = s1_chk_q & (s1_oob_q | (diff_d > (DISP_WIDTH+1)'(s1_tol_q)));
  assign out_d    = reject_d ? INV_CODE : s1_dl_q;

  // Pipeline fill, output and counters
  logic [1:0]               fill_q;
  logic [OUTPUTDATAWID-1:0] out_q;
  logic                     valid_q;
  logic [CNT_WIDTH-1:0]     run_q, invcnt_q;
  logic                     sync_q;
  logic                     load_out;

  // Stage 2 only holds a real pixel once stage 1 has been loaded at least once
  assign load_out = beat & (fill_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      for (int k = 0; k < MAXDISPARITY-1; k++) rwin_q[k] <= '0;
      s1_dl_q   <= '0;
      s1_rsel_q <= '0;
      s1_sof_q  <= 1'b0;
      s1_oob_q  <= 1'b0;
      s1_chk_q  <= 1'b0;
      s1_tol_q  <= '0;
      fill_q    <= 2'd0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      run_q     <= '0;
      invcnt_q  <= '0;
      sync_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (beat) begin
        x_q       <= x_d;
        rwin_q[0] <= dr;
        for (int k = 1; k < MAXDISPARITY-1; k++) rwin_q[k] <= rwin_q[k-1];
        s1_dl_q   <= dl;
        s1_rsel_q <= rsel_d;
        s1_sof_q  <= sof_l;
        s1_oob_q  <= oob_d;
        s1_chk_q  <= check_en;
        s1_tol_q  <= tolerance;
        if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
        if (sof_l != sof_r) sync_q <= 1'b1;
      end
      if (load_out) begin
        valid_q <= 1'b1;
        out_q   <= {s1_sof_q, out_d};
        // The SOF pixel closes the previous frame and opens the new count
        if (s1_sof_q) begin
          invcnt_q <= run_q;
          run_q    <= CNT_WIDTH'(reject_d);
        end else if (reject_d && (run_q != '1)) begin
          run_q <= run_q + 1'b1;
        end
      end
    end
  end

  assign dispOutput_left       = out_q;
  assign dispOutput_left_valid = valid_q;
  assign invalid_count         = invcnt_q;
  assign sync_err              = sync_q;

endmodule

// File: tb/tb_lr_consistency_check_param.sv
module tb_lr_consistency_check_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, pixelEN, check_en;
  logic [8:0]  dl_in, dr_in;
  logic [3:0]  tol;
  logic [8:0]  dout, dout2;
  logic        v, v2, se, se2;
  logic [19:0] icnt;
  logic [3:0]  icnt2;

  lr_consistency_check_param dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pixelEN(pixelEN),
    .Disparity_Left(dl_in), .Disparity_Right(dr_in),
    .check_en(check_en), .tolerance(tol),
    .dispOutput_left(dout), .dispOutput_left_valid(v),
    .invalid_count(icnt), .sync_err(se)
  );

  lr_consistency_check_param #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .pixelEN(pixelEN),
    .Disparity_Left(dl_in), .Disparity_Right(dr_in),
    .check_en(check_en), .tolerance(tol),
    .dispOutput_left(dout2), .dispOutput_left_valid(v2),
    .invalid_count(icnt2), .sync_err(se2)
  );

  int         tests = 0;
  int         fails = 0;
  logic [8:0] expq[$];
  logic [7:0] mhist[63];
  int         mx;
  int         tfill;
  logic [8:0] last_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 63; k++) mhist[k] = 8'd0;
    mx = 0;
    tfill = 0;
    expq.delete();
    last_out = 9'd0;
  endtask

  // Reference behaviour of one beat; the expected output is queued in order
  task automatic model_push(input logic sl, input logic [7:0] l, input logic [7:0] r,
                            input logic c, input logic [3:0] t);
    int x, d, rs;
    logic oob, rej;
    x = sl ? 0 : ((mx == 639) ? 0 : mx + 1);
    if (l == 8'd0) rs = int'(r);
    else if (l < 8'd64) rs = int'(mhist[l-8'd1]);
    else rs = 0;
    oob = (l >= 8'd64) || (int'(l) > x);
    d = int'(l) - rs;
    if (d < 0) d = -d;
    rej = c && (oob || (d > int'(t)));
    expq.push_back({sl, rej ? 8'd0 : l});
    for (int k = 62; k > 0; k--) mhist[k] = mhist[k-1];
    mhist[0] = r;
    mx = x;
  endtask

  // Drive one cycle, then check valid and output at the following negedge
  task automatic step(input logic e, input logic p, input logic sl, input logic [7:0] l,
                      input logic sr, input logic [7:0] r, input logic c, input logic [3:0] t);
    logic vexp;
    en = e; pixelEN = p; dl_in = {sl, l}; dr_in = {sr, r}; check_en = c; tol = t;
    if (e && p) model_push(sl, l, r, c, t);
    vexp = e && p && (tfill >= 1);
    if (e && p && tfill < 2) tfill++;
    @(posedge clk);
    @(negedge clk);
    check("valid", 32'(v), 32'(vexp));
    check("valid_sat", 32'(v2), 32'(vexp));
    if (vexp && expq.size() != 0) last_out = expq.pop_front();
    check("dout", 32'(dout), 32'(last_out));
    check("dout_sat", 32'(dout2), 32'(last_out));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; pixelEN = 1'b0; dl_in = 9'd0; dr_in = 9'd0;
    check_en = 1'b1; tol = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(v), 32'd0);
    check("rst_icnt", 32'(icnt), 32'd0);
    check("rst_sync", 32'(se), 32'd0);
    rst_n = 1'b1;

    // Frame 1 row: dL = dR = 5, tolerance 0
    for (int i = 0; i < 640; i++) begin
      step(1'b1, 1'b1, i == 0, 8'd5, i == 0, 8'd5, 1'b1, 4'd0);
      if (i == 0) check("first_valid_early", 32'(v), 32'd0);
      if (i == 1) check("px0_out", 32'(dout), 32'h100);
      if (i == 6) check("px5_out", 32'(dout), 32'h005);
    end
    check("icnt_frame1_open", 32'(icnt), 32'd0);

    // dL = 10 against dR = 12 at tolerance 1 (rejected), then tolerance 2
    for (int j = 0; j < 20; j++) step(1'b1, 1'b1, 1'b0, 8'd10, 1'b0, 8'd12, 1'b1, 4'd1);
    for (int j = 0; j < 10; j++) begin
      step(1'b1, 1'b1, 1'b0, 8'd10, 1'b0, 8'd12, 1'b1, 4'd2);
      if (j == 0) check("tol1_reject", 32'(dout), 32'h000);
      if (j == 1) check("tol2_pass", 32'(dout), 32'h00a);
    end

    // dL beyond the search range, checked then bypassed
    for (int j = 0; j < 12; j++) begin
      step(1'b1, 1'b1, 1'b0, 8'd70, 1'b0, 8'd12, 1'b1, 4'd2);
      if (j == 1) check("oob_reject", 32'(dout), 32'h000);
    end
    for (int j = 0; j < 5; j++) begin
      step(1'b1, 1'b1, 1'b0, 8'd70, 1'b0, 8'd12, 1'b0, 4'd2);
      if (j == 1) check("bypass_pass", 32'(dout), 32'h046);
    end

    // Frame 2 SOF closes frame 1: 5 + 20 + 12 = 37 rejects
    step(1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 8'd0, 1'b1, 4'd0);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 4'd0);
    check("sof_out", 32'(dout), 32'h100);
    check("icnt_37", 32'(icnt), 32'd37);
    check("icnt_sat_15", 32'(icnt2), 32'd15);
    check("sync_clean", 32'(se), 32'd0);

    // Sparse random stream: pixelEN once every 8 cycles, some en-gated cycles
    for (int i = 0; i < 1200; i++) begin
      logic       e, p, c;
      logic [7:0] l, r;
      logic [3:0] t;
      e = (i % 16) != 12;
      p = ((i % 8) == 0) || ((i % 16) == 12);
      l = ($urandom_range(0, 9) == 0) ? 8'd70 : 8'($urandom_range(20, 30));
      r = 8'($urandom_range(20, 30));
      c = $urandom_range(0, 3) != 0;
      t = 4'($urandom_range(0, 15));
      step(e, p, 1'b0, l, 1'b0, r, c, t);
    end
    check("sync_after_random", 32'(se), 32'd0);

    // Right SOF one pixel late
    step(1'b1, 1'b1, 1'b1, 8'd5, 1'b0, 8'd5, 1'b1, 4'd0);
    check("sync_set", 32'(se), 32'd1);
    check("sync_set_sat", 32'(se2), 32'd1);
    step(1'b1, 1'b1, 1'b0, 8'd5, 1'b1, 8'd5, 1'b1, 4'd0);
    repeat (5) step(1'b1, 1'b1, 1'b0, 8'd5, 1'b0, 8'd5, 1'b1, 4'd0);
    check("sync_sticky", 32'(se), 32'd1);

    // Mid-row asynchronous reset
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 8'd3, 1'b1, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_dout", 32'(dout), 32'd0);
    check("async_valid", 32'(v), 32'd0);
    check("async_icnt", 32'(icnt), 32'd0);
    check("async_sync", 32'(se), 32'd0);
    check("async_icnt_sat", 32'(icnt2), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b1, 8'd7, 1'b1, 8'd7, 1'b1, 4'd0);
    check("refill_valid_1", 32'(v), 32'd0);
    step(1'b1, 1'b1, 1'b0, 8'd7, 1'b0, 8'd7, 1'b1, 4'd0);
    check("refill_valid_2", 32'(v), 32'd1);
    check("refill_px0", 32'(dout), 32'h100);
    step(1'b1, 1'b1, 1'b0, 8'd7, 1'b0, 8'd7, 1'b1, 4'd0);
    step(1'b0, 1'b0, 1'b0, 8'd7, 1'b0, 8'd7, 1'b1, 4'd0);
    check("refill_icnt", 32'(icnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
